// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the mem_responder (slave).
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        gnt;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata, wstrb, rready,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata, wstrb, rready,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with fixed response latency.
// Optional macro MEM_RESPONDER_MISALIGN_ERR_EN: flag addr[1:0] != 0 as an error.
//
//   state | meaning
//   IDLE  | gnt high, waiting for a request
//   WAIT  | request latched, latency counter running down
//   RESP  | response presented, holding until rready
module mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic clk_i,
   input  logic reset_ni,
   mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [29:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        misal_q, misal_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        mem_we;
   logic        bad;
   logic [AW-1:0] widx;

   logic [31:0] mem_q [DEPTH];

   assign widx = idx_q[AW-1:0];
   assign bad  = (idx_q >= 30'(DEPTH)) | misal_q;

   assign bus.gnt    = (state_q == IDLE) & reset_ni;
   assign bus.rvalid = (state_q == RESP);
   assign bus.rdata  = rdata_q;
   assign bus.err    = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      misal_d = misal_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               state_d = WAIT;
               cnt_d   = 4'(LATENCY - 1);
               we_d    = bus.we;
               idx_d   = bus.addr[31:2];
               wdata_d = bus.wdata;
               wstrb_d = bus.wstrb;
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
               misal_d = (bus.addr[1:0] != 2'b00);
`else
               misal_d = 1'b0;
`endif
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               err_d   = bad;
               mem_we  = we_q & ~bad;
               rdata_d = (!we_q && !bad) ? mem_q[widx] : 32'h0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.rready) begin
               state_d = IDLE;
               rdata_d = 32'h0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= 30'd0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
         misal_q <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         misal_q <= misal_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) mem_q[widx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus hand-written corner sequences.
module tb_mem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic clk;
   logic reset_ni;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_responder_if bus ();

   mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic do_txn(input string nm, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic e_err, input logic [31:0] e_rd);
      @(negedge clk);
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.wstrb = s;
      bus.rready = 1'b0;
      check({nm, ":gnt"}, 32'(bus.gnt), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk); #1;
         check({nm, ":rvalid_lat"}, 32'(bus.rvalid), (k == LAT) ? 32'd1 : 32'd0);
      end
      check({nm, ":rdata"}, bus.rdata, e_rd);
      check({nm, ":err"}, 32'(bus.err), 32'(e_err));
      @(negedge clk);
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      check({nm, ":rvalid_done"}, 32'(bus.rvalid), 32'd0);
      check({nm, ":gnt_idle"}, 32'(bus.gnt), 32'd1);
   endtask

   initial begin
      reset_ni = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
      bus.wstrb = 4'h0; bus.rready = 1'b0;

      vecs.push_back('{"st64",      1'b1, 32'h64,  32'h19,        4'hF, 1'b0, 32'h0});
      vecs.push_back('{"ld64",      1'b0, 32'h64,  32'h0,         4'hF, 1'b0, 32'h19});
      vecs.push_back('{"st60full",  1'b1, 32'h60,  32'hAABBCCDD,  4'hF, 1'b0, 32'h0});
      vecs.push_back('{"st60strb",  1'b1, 32'h60,  32'h11223344,  4'h5, 1'b0, 32'h0});
      vecs.push_back('{"ld60",      1'b0, 32'h60,  32'h0,         4'hF, 1'b0, 32'hAA22CC44});
      vecs.push_back('{"ld400",     1'b0, 32'h400, 32'h0,         4'hF, 1'b1, 32'h0});
      vecs.push_back('{"st0",       1'b1, 32'h0,   32'h12345678,  4'hF, 1'b0, 32'h0});
      vecs.push_back('{"st400",     1'b1, 32'h400, 32'hFFFFFFFF,  4'hF, 1'b1, 32'h0});
      vecs.push_back('{"ld0",       1'b0, 32'h0,   32'h0,         4'hF, 1'b0, 32'h12345678});
      vecs.push_back('{"st64nostrb",1'b1, 32'h64,  32'hDEADBEEF,  4'h0, 1'b0, 32'h0});
      vecs.push_back('{"ld64again", 1'b0, 32'h64,  32'h0,         4'hF, 1'b0, 32'h19});
      vecs.push_back('{"ld60strb0", 1'b0, 32'h60,  32'h0,         4'h0, 1'b0, 32'hAA22CC44});
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
      vecs.push_back('{"ld62",      1'b0, 32'h62,  32'h0,         4'hF, 1'b1, 32'h0});
`else
      vecs.push_back('{"ld62",      1'b0, 32'h62,  32'h0,         4'hF, 1'b0, 32'hAA22CC44});
`endif
      vecs.push_back('{"st3fc",     1'b1, 32'h3FC, 32'hCAFEF00D,  4'hF, 1'b0, 32'h0});
      vecs.push_back('{"ld3fc",     1'b0, 32'h3FC, 32'h0,         4'hF, 1'b0, 32'hCAFEF00D});
      vecs.push_back('{"st10",      1'b1, 32'h10,  32'h0BADF00D,  4'hF, 1'b0, 32'h0});

      #12;
      check("rst:gnt",    32'(bus.gnt),    32'd0);
      check("rst:rvalid", 32'(bus.rvalid), 32'd0);
      check("rst:err",    32'(bus.err),    32'd0);
      check("rst:rdata",  bus.rdata,       32'h0);
      @(negedge clk);
      reset_ni = 1'b1;
      #1;
      check("rst:gnt_after", 32'(bus.gnt), 32'd1);

      foreach (vecs[i])
         do_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                vecs[i].exp_err, vecs[i].exp_rdata);

      // Backpressure: hold rready low with competing requests.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h64; bus.rready = 1'b0;
      @(posedge clk); #1;
      bus.req = 1'b0;
      for (int k = 0; k < LAT; k++) @(posedge clk);
      #1;
      check("hold:rvalid_up", 32'(bus.rvalid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h64;
         bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
         @(posedge clk); #1;
         check("hold:rvalid", 32'(bus.rvalid), 32'd1);
         check("hold:rdata",  bus.rdata,       32'h19);
         check("hold:gnt",    32'(bus.gnt),    32'd0);
      end
      @(negedge clk);
      bus.req = 1'b0; bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      check("hold:rvalid_done", 32'(bus.rvalid), 32'd0);
      check("hold:gnt_idle",    32'(bus.gnt),    32'd1);
      do_txn("hold:ld64", 1'b0, 32'h64, 32'h0, 4'hF, 1'b0, 32'h19);

      // Reset during WAIT drops the pending store.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h10; bus.wdata = 32'hFFFF_FFFF;
      bus.wstrb = 4'hF;
      @(posedge clk); #1;
      bus.req = 1'b0;
      #1 reset_ni = 1'b0;
      #1;
      check("rstwait:gnt", 32'(bus.gnt), 32'd0);
      @(posedge clk); #1;
      check("rstwait:rvalid", 32'(bus.rvalid), 32'd0);
      check("rstwait:err",    32'(bus.err),    32'd0);
      @(negedge clk);
      reset_ni = 1'b1;
      #1;
      check("rstwait:gnt_after", 32'(bus.gnt), 32'd1);
      do_txn("rstwait:ld10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0BADF00D);

      // Reset in RESP clears outputs without a clock edge.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h3FC;
      @(posedge clk); #1;
      bus.req = 1'b0;
      for (int k = 0; k < LAT; k++) @(posedge clk);
      #1;
      check("rstresp:rvalid_up", 32'(bus.rvalid), 32'd1);
      #2 reset_ni = 1'b0;
      #1;
      check("rstresp:rvalid", 32'(bus.rvalid), 32'd0);
      check("rstresp:rdata",  bus.rdata,       32'h0);
      @(negedge clk);
      reset_ni = 1'b1;
      do_txn("rstresp:ld3fc", 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, memory size in 32-bit words (power of 2).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance edge to response; legal range 1..15.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req  input  1  initiator request valid.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; word index = addr[31:2].
REQ-008 wdata  input  32  store data.
REQ-009 wstrb  input  4  byte enables for a store; bit i covers wdata[8i+7:8i].
REQ-010 gnt  output  1  request accepted this cycle when req & gnt at the rising edge.
REQ-011 rvalid  output  1  response valid.
REQ-012 rready  input  1  initiator accepts response when rvalid & rready at the rising edge.
REQ-013 rdata  output  32  load data; 0 for stores and errors.
REQ-014 err  output  1  response is an error; qualified by rvalid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 gnt SHALL be 1 only in IDLE; the acceptance edge latches we, addr, wdata, wstrb and moves IDLE->WAIT.
REQ-017 req and all request inputs SHALL be ignored outside IDLE; at most one transaction outstanding.
REQ-018 A down-counter SHALL load LATENCY-1 on acceptance; WAIT->RESP on the edge where it is 0, so rvalid rises exactly LATENCY cycles after the acceptance edge.
REQ-019 A legal store SHALL update only the enabled bytes of the addressed word on the WAIT->RESP edge; wstrb=0000 SHALL complete with no change.
REQ-020 A legal load SHALL present the full addressed word on rdata while rvalid=1; wstrb SHALL be ignored for loads.
REQ-021 rvalid, rdata and err SHALL be held stable in RESP until rvalid & rready; that edge SHALL return to IDLE.
REQ-022 A request accepted in the cycle directly after returning to IDLE SHALL proceed normally; no bubble beyond the IDLE cycle.
REQ-023 addr[31:2] >= DEPTH SHALL give err=1, rdata=0 and no memory write.
REQ-024 A store and a subsequent load to the same word SHALL return the stored data with no stale read.

Reset
REQ-025 Asserting reset SHALL force state IDLE, counter 0, rvalid=0, err=0, rdata=0 and gnt=0 while reset is low, taking effect without a clock edge.
REQ-026 Reset during WAIT SHALL discard the pending transaction; a pending store SHALL NOT be written.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 gnt SHALL become 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro MEM_RESPONDER_MISALIGN_ERR_EN defined: addr[1:0] != 00 SHALL give err=1, rdata=0 and no write, with normal latency.
REQ-030 Macro MEM_RESPONDER_MISALIGN_ERR_EN undefined: addr[1:0] SHALL be ignored, and the access goes to word addr[31:2].

Verification
REQ-031 Store addr=0x64, wdata=0x19, wstrb=1111, then load 0x64 -> store rvalid 2 cycles after acceptance with err=0; load rdata=0x00000019.
REQ-032 Word 0x60 holds 0xAABBCCDD; store wdata=0x11223344, wstrb=0101; load 0x60 -> rdata=0xAA22CC44.
REQ-033 Load 0x400 with DEPTH=256 -> rvalid with err=1, rdata=0; memory unchanged.
REQ-034 Hold rready=0 for 5 cycles in RESP -> rvalid and rdata stable, gnt=0, new req ignored; rready=1 -> IDLE next cycle.
REQ-035 Store to 0x10 with reset pulsed low during WAIT -> rvalid=0 immediately; load 0x10 after reset returns the old value.
REQ-036 Load 0x62 -> with MEM_RESPONDER_MISALIGN_ERR_EN defined: err=1; undefined: data of word 0x60 with err=0.
